sram_read_part: RTL and testbench



---
 rtl/sram_read_part_pkg.sv | 26 ++
 rtl/sram_rd_req_fifo.sv | 49 ++++
 rtl/sram_read_part.sv | 137 +++++++++++++
 tb/tb_sram_read_part.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_read_part_pkg.sv
// Shared types, default widths and helpers for the SRAM read-request path.
package sram_read_part_pkg;

    localparam int unsigned SA_NUM         = 3;
    localparam int unsigned SRAM_ADDR_SIZE = 12;
    localparam int unsigned SA_WB_WIDTH    = 16;
    localparam int unsigned SA_IDX_W       = (SA_NUM > 1) ? $clog2(SA_NUM) : 1;

    typedef struct packed {
        logic [SRAM_ADDR_SIZE-1:0] addr;
    } RD_REQ_ENTRY_t;

    typedef struct packed {
        logic                valid;
        logic [SA_IDX_W-1:0] idx;
    } RD_TAG_t;

    // (base + off) mod num for base, off < num, without a divider.
    function automatic int unsigned rr_wrap(int unsigned base, int unsigned off,
                                            int unsigned num);
        int unsigned sum;
        sum = base + off;
        return (sum >= num) ? sum - num : sum;
    endfunction

endpackage

// File: rtl/sram_rd_req_fifo.sv
// Per-SA read-request FIFO: registered storage, full/empty flags, no fall-through.
module sram_rd_req_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/sram_read_part.sv
// Queues per-SA SRAM read requests, round-robins them onto one read port, returns data.
// Optional same-cycle bypass of an empty FIFO: define SRAM_RD_BYPASS_EN.
module sram_read_part
    import sram_read_part_pkg::*;
#(
    parameter int unsigned NUM_SA    = SA_NUM,
    parameter int unsigned ADDR_W    = SRAM_ADDR_SIZE,
    parameter int unsigned DATA_W    = SA_WB_WIDTH,
    parameter int unsigned REQ_DEPTH = 4,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_SA-1:0]        req_valid,
    input  logic [NUM_SA*ADDR_W-1:0] req_addr,
    output logic [NUM_SA-1:0]        req_ready,
    output logic                     sram_rd_en,
    output logic [ADDR_W-1:0]        sram_rd_addr,
    input  logic [DATA_W-1:0]        sram_rd_data,
    output logic [NUM_SA-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_data
);

    localparam int unsigned IDX_W = (NUM_SA > 1) ? $clog2(NUM_SA) : 1;

    logic [NUM_SA-1:0] w_full;
    logic [NUM_SA-1:0] w_empty;
    logic [NUM_SA-1:0] w_push;
    logic [NUM_SA-1:0] w_pop;
    logic [NUM_SA-1:0] w_req;
    logic [NUM_SA-1:0] w_gnt_oh;
    logic [NUM_SA-1:0] w_byp_gnt;
    logic [ADDR_W-1:0] w_head [NUM_SA];
    logic              w_gnt_vld;
    logic [IDX_W-1:0]  w_gnt_idx;

    logic [IDX_W-1:0]  r_ptr;
    logic [RD_LAT-1:0] r_tag_vld;
    logic [IDX_W-1:0]  r_tag_idx [RD_LAT];

    for (genvar gi = 0; gi < NUM_SA; gi++) begin : g_fifo
        sram_rd_req_fifo #(
            .WIDTH (ADDR_W),
            .DEPTH (REQ_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .resetn  (resetn),
            .i_push  (w_push[gi]),
            .i_data  (req_addr[gi*ADDR_W +: ADDR_W]),
            .i_pop   (w_pop[gi]),
            .o_data  (w_head[gi]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi])
        );
    end

    assign req_ready = ~w_full;

`ifdef SRAM_RD_BYPASS_EN
    assign w_req = ~w_empty | (req_valid & w_empty);
`else
    assign w_req = ~w_empty;
`endif

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = NUM_SA - 1; k >= 0; k--) begin
            if (w_req[rr_wrap(int'(r_ptr), k, NUM_SA)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IDX_W'(rr_wrap(int'(r_ptr), k, NUM_SA));
            end
        end
    end

    always_comb begin
        w_gnt_oh  = '0;
        w_byp_gnt = '0;
        w_pop     = '0;
        w_push    = '0;
        for (int i = 0; i < NUM_SA; i++) begin
            w_gnt_oh[i] = w_gnt_vld && (w_gnt_idx == IDX_W'(i));
`ifdef SRAM_RD_BYPASS_EN
            w_byp_gnt[i] = w_gnt_oh[i] && w_empty[i];
`endif
            w_pop[i]  = w_gnt_oh[i] && !w_empty[i];
            w_push[i] = req_valid[i] && !w_full[i] && !w_byp_gnt[i];
        end
    end

    always_comb begin
        sram_rd_en   = w_gnt_vld;
        sram_rd_addr = '0;
        if (w_gnt_vld) begin
            sram_rd_addr = w_head[w_gnt_idx];
`ifdef SRAM_RD_BYPASS_EN
            if (w_empty[w_gnt_idx]) sram_rd_addr = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (w_gnt_vld) begin
            r_ptr <= (w_gnt_idx == IDX_W'(NUM_SA - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Tag pipe tracks which SA owns the word arriving RD_LAT cycles after the strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tag_vld <= '0;
            for (int s = 0; s < RD_LAT; s++) r_tag_idx[s] <= '0;
        end else begin
            r_tag_vld[0] <= w_gnt_vld;
            r_tag_idx[0] <= w_gnt_idx;
            for (int s = 1; s < RD_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (r_tag_vld[RD_LAT-1]) begin
            for (int i = 0; i < NUM_SA; i++) begin
                rsp_valid[i] = (r_tag_idx[RD_LAT-1] == IDX_W'(i));
            end
            rsp_data = sram_rd_data;
        end
    end

endmodule

// File: tb/tb_sram_read_part.sv
// Bench for sram_read_part: directed vector table, hand sequences, and a queue-based model.
module tb_sram_read_part;

    localparam int NSA   = 3;
    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
`ifdef SRAM_RD_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic            clk;
    logic            resetn;
    logic [NSA-1:0]  req_valid;
    logic [NSA*AW-1:0] req_addr;

    logic [NSA-1:0]  ready1, rspv1, ready2, rspv2;
    logic            en1, en2;
    logic [AW-1:0]   addr1, addr2;
    logic [DW-1:0]   sdata1, sdata2, rspd1, rspd2;

    sram_read_part #(
        .NUM_SA(NSA), .ADDR_W(AW), .DATA_W(DW), .REQ_DEPTH(DEPTH), .RD_LAT(1)
    ) u_dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready1), .sram_rd_en(en1), .sram_rd_addr(addr1),
        .sram_rd_data(sdata1), .rsp_valid(rspv1), .rsp_data(rspd1)
    );

    sram_read_part #(
        .NUM_SA(NSA), .ADDR_W(AW), .DATA_W(DW), .REQ_DEPTH(DEPTH), .RD_LAT(2)
    ) u_dut_l2 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready2), .sram_rd_en(en2), .sram_rd_addr(addr2),
        .sram_rd_data(sdata2), .rsp_valid(rspv2), .rsp_data(rspd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] p;
        if (a == 12'h010) return 16'h00A5;
        p = {20'd0, a} * 32'd40503;
        return p[15:0] ^ 16'h5A3C;
    endfunction

    // SRAM models with latency 1 and 2.
    logic [DW-1:0] r_sram1;
    logic [DW-1:0] r_sram2 [2];
    always @(posedge clk) begin
        r_sram1    <= en1 ? mem_word(addr1) : 16'hDEAD;
        r_sram2[0] <= en2 ? mem_word(addr2) : 16'hDEAD;
        r_sram2[1] <= r_sram2[0];
    end
    assign sdata1 = r_sram1;
    assign sdata2 = r_sram2[1];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (RD_LAT=1 instance) ----------------
    typedef struct packed {
        logic          v;
        logic [1:0]    idx;
        logic [AW-1:0] addr;
    } tag_t;

    logic [AW-1:0] m_q [NSA][$];
    int            m_ptr = 0;
    tag_t          m_tag = '0;
    bit            chk_on = 1'b0;
    bit            fair_on = 1'b0;
    bit            saw_full = 1'b0;
    int            fair_cnt [NSA];

    function automatic void model_eval(output logic [NSA-1:0] rdy, output logic en,
                                       output logic [AW-1:0] addr, output int g,
                                       output logic byp);
        rdy  = '0;
        en   = 1'b0;
        addr = '0;
        g    = -1;
        byp  = 1'b0;
        for (int i = 0; i < NSA; i++) rdy[i] = (m_q[i].size() < DEPTH);
        for (int k = 0; k < NSA; k++) begin
            int i;
            i = (m_ptr + k) % NSA;
            if (g < 0 && (m_q[i].size() > 0 || (BYP == 1 && req_valid[i] == 1'b1))) g = i;
        end
        if (g >= 0) begin
            en = 1'b1;
            if (m_q[g].size() > 0) begin
                addr = m_q[g][0];
            end else begin
                addr = req_addr[g*AW +: AW];
                byp  = 1'b1;
            end
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                for (int i = 0; i < NSA; i++) m_q[i].delete();
                m_ptr = 0;
                m_tag = '0;
            end else begin
                logic [NSA-1:0] rdy;
                logic           en, byp;
                logic [AW-1:0]  addr;
                int             g;
                model_eval(rdy, en, addr, g, byp);
                m_tag = '{v: en, idx: 2'(g < 0 ? 0 : g), addr: addr};
                if (g >= 0) begin
                    if (!byp) void'(m_q[g].pop_front());
                    m_ptr = (g + 1) % NSA;
                end
                for (int i = 0; i < NSA; i++) begin
                    if (req_valid[i] && rdy[i] && !(byp && g == i))
                        m_q[i].push_back(req_addr[i*AW +: AW]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                logic [NSA-1:0] rdy;
                logic           en, byp;
                logic [AW-1:0]  addr;
                int             g;
                model_eval(rdy, en, addr, g, byp);
                check("m_req_ready", ready1, rdy);
                check("m_rd_en", en1, en);
                check("m_rd_addr", addr1, addr);
                check("m_rsp_valid", rspv1, m_tag.v ? (3'b001 << m_tag.idx) : 3'b000);
                check("m_rsp_data", rspd1, m_tag.v ? mem_word(m_tag.addr) : 16'h0000);
                if (fair_on) begin
                    for (int i = 0; i < NSA; i++) if (rspv1[i]) fair_cnt[i]++;
                    if (ready1 != 3'b111) saw_full = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [NSA-1:0] v, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(3'b000, '0, '0, '0);
        next_cycle();
        next_cycle();
        resetn = 1'b1;
    endtask

    function automatic logic [AW-1:0] rnd_addr(input int hi);
        return AW'($urandom_range(0, hi));
    endfunction

    typedef struct packed {
        bit            rst;
        logic [2:0]    v;
        logic [AW-1:0] a0, a1, a2;
        logic          en;
        logic [AW-1:0] ea;
        logic [2:0]    rv;
        logic [DW-1:0] rd;
    } vec_t;

    function automatic vec_t mk(bit rst, logic [2:0] v, logic [AW-1:0] a0, logic [AW-1:0] a1,
                                logic [AW-1:0] a2, logic en, logic [AW-1:0] ea,
                                logic [2:0] rv, logic [DW-1:0] rd);
        return '{rst: rst, v: v, a0: a0, a1: a1, a2: a2, en: en, ea: ea, rv: rv, rd: rd};
    endfunction

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int bound;
        resetn = 1'b0;
        drive(3'b000, '0, '0, '0);
        for (int i = 0; i < NSA; i++) fair_cnt[i] = 0;

        // Reset state, sampled while reset is held.
        #3;
        check("rst_ready", ready1, 3'b111);
        check("rst_en", en1, 1'b0);
        check("rst_addr", addr1, 12'h000);
        check("rst_rspv", rspv1, 3'b000);
        check("rst_rspd", rspd1, 16'h0000);
        chk_on = 1'b1;

        // Directed table: single request, then three simultaneous requests.
        if (BYP == 1) begin
            tbl.push_back(mk(1, 3'b001, 12'h010, 0, 0, 1, 12'h010, 3'b000, 0));
            tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b001, 16'h00A5));
            tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 0));
            tbl.push_back(mk(1, 3'b111, 12'h001, 12'h002, 12'h003, 1, 12'h001, 3'b000, 0));
            tbl.push_back(mk(0, 3'b000, 0, 0, 0, 1, 12'h002, 3'b001, mem_word(12'h001)));
            tbl.push_back(mk(0, 3'b000, 0, 0, 0, 1, 12'h003, 3'b010, mem_word(12'h002)));
            tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b100, mem_word(12'h003)));
            tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 0));
        end else begin
            tbl.push_back(mk(1, 3'b001, 12'h010, 0, 0, 0, 0, 3'b000, 0));
            tbl.push_back(mk(0, 3'b000, 0, 0, 0, 1, 12'h010, 3'b000, 0));
            tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b001, 16'h00A5));
            tbl.push_back(mk(1, 3'b111, 12'h001, 12'h002, 12'h003, 0, 0, 3'b000, 0));
            tbl.push_back(mk(0, 3'b000, 0, 0, 0, 1, 12'h001, 3'b000, 0));
            tbl.push_back(mk(0, 3'b000, 0, 0, 0, 1, 12'h002, 3'b001, mem_word(12'h001)));
            tbl.push_back(mk(0, 3'b000, 0, 0, 0, 1, 12'h003, 3'b010, mem_word(12'h002)));
            tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b100, mem_word(12'h003)));
        end
        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].rst) do_reset();
            drive(tbl[r].v, tbl[r].a0, tbl[r].a1, tbl[r].a2);
            @(negedge clk);
            check($sformatf("tbl%0d_en", r), en1, tbl[r].en);
            check($sformatf("tbl%0d_addr", r), addr1, tbl[r].ea);
            check($sformatf("tbl%0d_rspv", r), rspv1, tbl[r].rv);
            check($sformatf("tbl%0d_rspd", r), rspd1, tbl[r].rd);
            next_cycle();
        end

        // All three SAs saturate: strict rotation, FIFOs fill.
        do_reset();
        for (int c = 0; c < 60; c++) begin
            if (c == 5) fair_on = 1'b1;
            if (c == 53) fair_on = 1'b0;
            drive(3'b111, rnd_addr(4095), rnd_addr(4095), rnd_addr(4095));
            next_cycle();
        end
        for (int i = 0; i < NSA; i++) check($sformatf("fair_sa%0d", i), fair_cnt[i], 16);
        check("ready_toggled", saw_full, 1'b1);
        drive(3'b000, '0, '0, '0);
        repeat (16) next_cycle();

        // SA0/SA2 stream, SA1 requests once and must be served promptly.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive(3'b101, rnd_addr(12'h7FF), 0, rnd_addr(12'h7FF));
            next_cycle();
        end
        d = -1;
        bound = 3 - BYP;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) drive(3'b111, rnd_addr(12'h7FF), 12'hABC, rnd_addr(12'h7FF));
            else        drive(3'b101, rnd_addr(12'h7FF), 0, rnd_addr(12'h7FF));
            @(negedge clk);
            if (d < 0 && en1 && addr1 == 12'hABC) d = c;
            next_cycle();
        end
        check("sa1_served", (d >= 0 && d <= bound) ? 1 : 0, 1);
        drive(3'b000, '0, '0, '0);
        repeat (16) next_cycle();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            drive(3'($urandom_range(0, 7)), rnd_addr(4095), rnd_addr(4095), rnd_addr(4095));
            next_cycle();
        end
        drive(3'b000, '0, '0, '0);
        repeat (16) next_cycle();

        // Reset with two responses in flight on the RD_LAT=2 instance.
        do_reset();
        drive(3'b011, 12'h100, 12'h200, 0);
        next_cycle();
        drive(3'b000, '0, '0, '0);
        repeat (2 - BYP) next_cycle();
        @(negedge clk);
        check("l2_pre_rspv", rspv2, 3'b001);
        check("l2_pre_rspd", rspd2, mem_word(12'h100));
        #2;
        resetn = 1'b0;
        #1;
        check("l2_async_rspv", rspv2, 3'b000);
        check("l1_async_rspv", rspv1, 3'b000);
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("l2_post_rspv", rspv2, 3'b000);
            check("l2_post_ready", ready2, 3'b111);
            next_cycle();
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive(3'b100, 0, 0, 12'h055);
            else        drive(3'b000, '0, '0, '0);
            @(negedge clk);
            check("l2_new_en", en2, (c == 1 - BYP) ? 1'b1 : 1'b0);
            check("l2_new_addr", addr2, (c == 1 - BYP) ? 12'h055 : 12'h000);
            check("l2_new_rspv", rspv2, (c == 3 - BYP) ? 3'b100 : 3'b000);
            check("l2_new_rspd", rspd2, (c == 3 - BYP) ? mem_word(12'h055) : 16'h0000);
            next_cycle();
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
